// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit FSM states, frame constants and
// default timing values used by the host transmitter, receiver and board top.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_START,
    ST_SEND,
    ST_ACK,
    ST_WAIT_IDLE
  } ps2_tx_state_t;

  // Device clock falls that carry host bits: 8 data, parity, stop.
  localparam int   PS2_FRAME_FALLS    = 10;
  // Level the device drives on PS2_DATA to acknowledge a frame.
  localparam logic PS2_ACK            = 1'b0;

  // 100 us inhibit and 15 ms frame budget at a 100 kHz clk.
  localparam int   PS2_INHIBIT_CYCLES = 10;
  localparam int   PS2_TIMEOUT_CYCLES = 1500;

  // Odd parity bit: makes the total number of ones in data+parity odd.
  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge strobe
// taken between the synchronized level and its one-cycle-old copy.
module ps2_line_sync (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic level_o,
  output logic fall_o
);

  logic meta_q, sync_q, prev_q;

  // Idle PS/2 lines float high, so the chain resets to 1 to avoid a
  // spurious fall on the first cycles out of reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= line_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign fall_o  = prev_q & ~sync_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibits the bus, issues a start bit,
// shifts out one byte with odd parity and stop, then collects the device ACK.
// Only open-drain output enables are produced; the board top builds the pads.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = PS2_INHIBIT_CYCLES,
  parameter int TIMEOUT_CYCLES = PS2_TIMEOUT_CYCLES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  ps2_tx_state_t    state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0]       bit_cnt_q;
  logic [9:0]       shreg_q;
  logic             ack_q;
  logic             clk_oe_q, data_oe_q, busy_q, done_q, error_q;

  logic clk_lvl, clk_fall, data_lvl, data_fall_unused;
  logic active_d, timeout_d;

  ps2_line_sync u_clk_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_clk_in),
    .level_o(clk_lvl),
    .fall_o (clk_fall)
  );

  ps2_line_sync u_data_sync (
    .clk    (clk),
    .rst    (rst),
    .line_i (ps2_data_in),
    .level_o(data_lvl),
    .fall_o (data_fall_unused)
  );

  // Frame budget runs from clock release until the bus returns idle.
  assign active_d  = (state_q == ST_START) || (state_q == ST_SEND) ||
                     (state_q == ST_ACK)   || (state_q == ST_WAIT_IDLE);
  assign timeout_d = active_d && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

  // Transmit FSM; every output is a register written here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      ack_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      error_q <= 1'b0;
      if (active_d) cnt_q <= cnt_q + 1'b1;
      // Timeout is checked first so it beats a fall landing in the same cycle.
      if (timeout_d) begin
        state_q   <= ST_IDLE;
        cnt_q     <= '0;
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        error_q   <= 1'b1;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (wr_en) begin
              state_q  <= ST_INHIBIT;
              cnt_q    <= '0;
              clk_oe_q <= 1'b1;
              busy_q   <= 1'b1;
              shreg_q  <= {1'b1, ps2_odd_parity(wr_data), wr_data};
            end
          end
          ST_INHIBIT: begin
            cnt_q <= cnt_q + 1'b1;
            // Start bit overlaps the final inhibit cycle.
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 2)) data_oe_q <= 1'b1;
            if (cnt_q == CNT_W'(INHIBIT_CYCLES - 1)) begin
              state_q   <= ST_START;
              clk_oe_q  <= 1'b0;
              data_oe_q <= 1'b1;
              // Zeroed here so the START cycle is cycle 0 of the budget.
              cnt_q     <= '0;
            end
          end
          ST_START: begin
            bit_cnt_q <= '0;
            state_q   <= ST_SEND;
          end
          ST_SEND: begin
            if (clk_fall) begin
              data_oe_q <= ~shreg_q[0];
              shreg_q   <= shreg_q >> 1;
              bit_cnt_q <= bit_cnt_q + 1'b1;
              if (bit_cnt_q == 4'(PS2_FRAME_FALLS - 1)) state_q <= ST_ACK;
            end
          end
          ST_ACK: begin
            if (clk_fall) begin
              ack_q   <= data_lvl;
              state_q <= ST_WAIT_IDLE;
            end
          end
          ST_WAIT_IDLE: begin
            if (clk_lvl && data_lvl) begin
              state_q <= ST_IDLE;
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              done_q  <= (ack_q == PS2_ACK);
              error_q <= (ack_q != PS2_ACK);
            end
          end
          default: begin
            state_q   <= ST_IDLE;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            busy_q    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ps2_clk_oe  = clk_oe_q;
  assign ps2_data_oe = data_oe_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural keyboard clocks frames out of the host,
// a scoreboard queue holds the expected frame/outcome per request and a
// monitor pops it on every done/error pulse.
module tb_ps2_host_tx;

  localparam int HALF = 8;

  logic       clk = 1'b0;
  logic       rst_n, wr_en;
  logic [7:0] wr_data;
  logic       clk_oe, data_oe, busy, done, error;
  logic       dev_clk = 1'b1, dev_data = 1'b1;
  logic       pc_line, pd_line;

  logic       rst2_n, wr_en2;
  logic [7:0] wr_data2;
  logic       clk_oe2, data_oe2, busy2, done2, error2;
  logic       pc2_line, pd2_line;

  always #5 clk = ~clk;

  // Open-drain wired-AND of host enables and device drive, pulled up.
  assign pc_line  = ~clk_oe & dev_clk;
  assign pd_line  = ~data_oe & dev_data;
  assign pc2_line = ~clk_oe2;
  assign pd2_line = ~data_oe2;

  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(1500)) dut (
    .clk(clk), .rst(rst_n), .ps2_clk_in(pc_line), .ps2_data_in(pd_line),
    .ps2_clk_oe(clk_oe), .ps2_data_oe(data_oe), .wr_en(wr_en), .wr_data(wr_data),
    .busy(busy), .done(done), .error(error)
  );

  // Second instance with no device attached, for the timeout path.
  ps2_host_tx #(.INHIBIT_CYCLES(10), .TIMEOUT_CYCLES(50)) dut_to (
    .clk(clk), .rst(rst2_n), .ps2_clk_in(pc2_line), .ps2_data_in(pd2_line),
    .ps2_clk_oe(clk_oe2), .ps2_data_oe(data_oe2), .wr_en(wr_en2), .wr_data(wr_data2),
    .busy(busy2), .done(done2), .error(error2)
  );

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  typedef struct {
    logic [9:0] bits;
    logic       ack;
  } exp_t;

  exp_t       sb[$];
  logic [9:0] rx_bits = '0;
  int         done_cnt = 0;
  int         err_cnt  = 0;

  // Monitor: every done/error pulse consumes one scoreboard entry.
  initial begin
    exp_t e;
    logic pulse_prev;
    pulse_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1) begin
        if (pulse_prev) chk("pulse_width", {30'd0, done, error}, 32'd0);
        if (done || error) begin
          if (done)  done_cnt++;
          if (error) err_cnt++;
          if (sb.size() == 0) begin
            chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
          end else begin
            e = sb.pop_front();
            chk("outcome", {30'd0, done, error}, e.ack ? 32'd2 : 32'd1);
            chk("frame_bits", {22'd0, rx_bits}, {22'd0, e.bits});
            chk("busy_at_pulse", {31'd0, busy}, 32'd0);
            chk("lines_at_pulse", {30'd0, clk_oe, data_oe}, 32'd0);
          end
        end
        pulse_prev = done | error;
      end else begin
        pulse_prev = 1'b0;
      end
    end
  end

  // Keyboard model: waits for the request-to-send, then clocks nfalls
  // cycles, sampling PS2_DATA on each rising edge; fall 11 carries the ACK.
  task automatic dev_frame(input logic ack, input int nfalls);
    int n;
    logic [9:0] r;
    n = 0;
    while (!clk_oe && n < 200) begin @(negedge clk); n++; end
    chk("dev_saw_inhibit", {31'd0, clk_oe}, 32'd1);
    n = 0;
    while (clk_oe && n < 200) begin @(negedge clk); n++; end
    chk("clk_released", {31'd0, clk_oe}, 32'd0);
    chk("start_bit", {31'd0, pd_line}, 32'd0);
    repeat (4) @(negedge clk);
    r = '0;
    for (int k = 1; k <= nfalls; k++) begin
      if (k == 11) begin
        dev_data = ack ? 1'b0 : 1'b1;
        @(negedge clk);
      end
      dev_clk = 1'b0;
      repeat (HALF) @(negedge clk);
      if (k == nfalls && nfalls < 11) return;
      if (k <= 10) r[k-1] = pd_line;
      if (k == 10) rx_bits = r;
      dev_clk = 1'b1;
      repeat (HALF) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic send(input logic [7:0] b, input logic [9:0] bits, input logic ack, input logic push);
    exp_t e;
    @(negedge clk);
    wr_en = 1'b1;
    wr_data = b;
    if (push) begin
      e.bits = bits;
      e.ack  = ack;
      sb.push_back(e);
    end
    @(negedge clk);
    wr_en = 1'b0;
    chk("busy_next_cycle", {31'd0, busy}, 32'd1);
    chk("clk_oe_next_cycle", {31'd0, clk_oe}, 32'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    chk("idle_reached", {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, hi, first_d;
    logic saw_done2;
    rst_n = 1'b0; rst2_n = 1'b0;
    wr_en = 1'b0; wr_data = '0; wr_en2 = 1'b0; wr_data2 = '0;
    #1;
    chk("reset_outputs", {27'd0, clk_oe, data_oe, busy, done, error}, 32'd0);
    chk("reset_outputs_to", {27'd0, clk_oe2, data_oe2, busy2, done2, error2}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst2_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1, parity 1, stop 1.
    fork
      dev_frame(1'b1, 11);
      send(8'hED, 10'h3ED, 1'b1, 1'b1);
    join
    wait_idle();
    repeat (5) @(negedge clk);

    // 0xF4: bits 0,0,1,0,1,1,1,1, parity 0, stop 1.
    fork
      dev_frame(1'b1, 11);
      send(8'hF4, 10'h2F4, 1'b1, 1'b1);
    join
    wait_idle();
    repeat (5) @(negedge clk);

    // NACK: device leaves data high at fall 11.
    fork
      dev_frame(1'b0, 11);
      send(8'hED, 10'h3ED, 1'b0, 1'b1);
    join
    wait_idle();
    repeat (2) @(negedge clk);
    chk("lines_after_nack", {30'd0, clk_oe, data_oe}, 32'd0);
    chk("nack_err_count", err_cnt, 32'd1);
    chk("nack_no_done", done_cnt, 32'd2);

    // wr_en with 0x00 mid-frame must be dropped.
    fork
      dev_frame(1'b1, 11);
      begin
        send(8'hED, 10'h3ED, 1'b1, 1'b1);
        repeat (60) @(negedge clk);
        chk("busy_mid_frame", {31'd0, busy}, 32'd1);
        wr_en = 1'b1; wr_data = 8'h00;
        @(negedge clk);
        wr_en = 1'b0;
      end
    join
    wait_idle();
    repeat (100) @(negedge clk);
    chk("no_queued_frame", {30'd0, busy, clk_oe}, 32'd0);
    chk("done_count_after_busy", done_cnt, 32'd3);

    // Reset after fall 4 of 0xF4 (bit3=0, so data_oe is 1 at that point).
    fork
      dev_frame(1'b1, 4);
      send(8'hF4, 10'h0, 1'b1, 1'b0);
    join
    chk("data_oe_after_fall4", {31'd0, data_oe}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("reset_mid_frame_lines", {30'd0, clk_oe, data_oe}, 32'd0);
    chk("reset_mid_frame_busy", {29'd0, busy, done, error}, 32'd0);
    @(negedge clk);
    dev_clk = 1'b1;
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    fork
      dev_frame(1'b1, 11);
      send(8'hED, 10'h3ED, 1'b1, 1'b1);
    join
    wait_idle();
    repeat (5) @(negedge clk);
    chk("done_count_final", done_cnt, 32'd4);
    chk("error_count_final", err_cnt, 32'd1);
    chk("scoreboard_empty", sb.size(), 32'd0);

    // Timeout instance: inhibit length, start bit timing, 50-cycle timeout.
    @(negedge clk);
    wr_en2 = 1'b1; wr_data2 = 8'hF4;
    @(negedge clk);
    wr_en2 = 1'b0;
    chk("to_busy_next", {31'd0, busy2}, 32'd1);
    hi = 0; first_d = -1; n = 0;
    while (clk_oe2 && n < 100) begin
      if (data_oe2 && first_d < 0) first_d = hi;
      hi++;
      @(negedge clk);
      n++;
    end
    chk("inhibit_len", hi, 32'd10);
    chk("start_bit_cycle", first_d, 32'd9);
    chk("start_bit_held", {31'd0, data_oe2}, 32'd1);
    n = 0; saw_done2 = 1'b0;
    while (!error2 && n < 200) begin
      @(negedge clk);
      n++;
      if (done2) saw_done2 = 1'b1;
    end
    chk("timeout_cycles", n, 32'd50);
    chk("timeout_no_done", {31'd0, saw_done2}, 32'd0);
    chk("timeout_busy", {31'd0, busy2}, 32'd0);
    chk("timeout_lines", {30'd0, clk_oe2, data_oe2}, 32'd0);
    @(negedge clk);
    chk("timeout_pulse_width", {31'd0, error2}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
